// File: rtl/regfile_param.sv
// Parametrised register file with byte-enable writes, optional hardwired zero
// register, optional write-to-read bypass and a post-reset clear sequencer.
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    reg_write,
  input  logic [ADDR_WIDTH-1:0]   write_reg,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strb,
  input  logic [ADDR_WIDTH-1:0]   read_reg1,
  input  logic [ADDR_WIDTH-1:0]   read_reg2,
  output logic [DATA_WIDTH-1:0]   read_data1,
  output logic [DATA_WIDTH-1:0]   read_data2,
  output logic                    ready
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_idx_q;
  logic                    ready_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    clr_en;
  logic                    rd_en;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   strb_mask;
  logic [DATA_WIDTH-1:0]   raw1, raw2;
  logic                    byp1, byp2;
  logic                    zero1, zero2;

  // Expand per-byte strobes into a bit mask used by both the write path and bypass.
  // NOTE: every always_comb output gets a default before any conditional update,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      strb_mask[8*b +: 8] = {8{write_strb[b]}};
    end
  end

  assign clr_en = rst_n && (state_q == ST_CLEAR);
  assign rd_en  = rst_n && (state_q == ST_READY);
  assign wr_en  = rd_en && reg_write && !(ZERO_REG && (write_reg == '0));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else if (state_q == ST_CLEAR) begin
      clr_idx_q <= clr_idx_q + ADDR_WIDTH'(1);
      if (&clr_idx_q) begin
        state_q <= ST_READY;
        ready_q <= 1'b1;
      end
    end
  end

  // NOTE: storage carries no reset; the clear sequencer zeroes it one entry per
  // cycle, which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[clr_idx_q] <= '0;
    end else if (wr_en) begin
      mem_q[write_reg] <= (mem_q[write_reg] & ~strb_mask) | (write_data & strb_mask);
    end
  end

  assign raw1  = mem_q[read_reg1];
  assign raw2  = mem_q[read_reg2];
  assign byp1  = BYPASS && wr_en && (write_reg == read_reg1);
  assign byp2  = BYPASS && wr_en && (write_reg == read_reg2);
  assign zero1 = ZERO_REG && (read_reg1 == '0);
  assign zero2 = ZERO_REG && (read_reg2 == '0);

  // Reads are forced to zero outside normal operation and for the hardwired entry.
  assign read_data1 = (!rd_en || zero1) ? '0 :
                      byp1 ? ((raw1 & ~strb_mask) | (write_data & strb_mask)) : raw1;
  assign read_data2 = (!rd_en || zero2) ? '0 :
                      byp2 ? ((raw2 & ~strb_mask) | (write_data & strb_mask)) : raw2;

  assign ready = ready_q;

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file: the next generation of the processor's 32x32 register file. Data width and depth are configurable, and writes carry byte enables. Register 0 can optionally be hardwired to zero, and an optional write-to-read bypass returns same-cycle write data. A synchronous clear sequencer zeroes every entry after reset and signals `ready` when done. It sits in the decode stage, between instruction decode (read addresses) and writeback (write port).

## Interface
- `DATA_WIDTH`, 32: register width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 5: address width; depth `DEPTH = 2**ADDR_WIDTH`.
- `ZERO_REG`, 1: when 1, entry 0 always reads 0 and writes to it are dropped.
- `BYPASS`, 1: when 1, a same-cycle write to a read address is forwarded to that read port.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `reg_write`  in  1  write enable.
- `write_reg`  in  ADDR_WIDTH  write address.
- `write_data`  in  DATA_WIDTH  write data.
- `write_strb`  in  DATA_WIDTH/8  byte enables; bit i covers `write_data[8i+7:8i]`.
- `read_reg1`  in  ADDR_WIDTH  read port 1 address.
- `read_reg2`  in  ADDR_WIDTH  read port 2 address.
- `read_data1`  out  DATA_WIDTH  read port 1 data (combinational).
- `read_data2`  out  DATA_WIDTH  read port 2 data (combinational).
- `ready`  out  1  high once the clear sequence has completed; writes are accepted only while high.

## Operation
- States:
  - CLEAR: sequencer is zeroing entries.
  - READY: normal operation.
- Register: `clr_idx` (ADDR_WIDTH bits).
- Reset: `rst_n` low at a rising edge sets state to CLEAR, `clr_idx` to 0 and `ready` to 0. This applies from any state, including mid-clear; the clear sequence restarts at index 0.
- CLEAR, each edge with `rst_n` high:
  - `registers[clr_idx]` is set to 0 and `clr_idx` increments.
  - On the edge that clears `DEPTH-1`, state moves to READY and `ready` goes to 1.
- CLEAR behaviour towards users:
  - `reg_write` is ignored; nothing is written.
  - Both read ports return 0.
- READY write: if `reg_write` is 1, then for every byte i with `write_strb[i]` set, byte i of `registers[write_reg]` takes byte i of `write_data`. Unselected bytes hold their value.
- Zero register: with `ZERO_REG` set, writes to address 0 are discarded and reads of address 0 return 0, independent of strobes and bypass.
- READY read: `read_dataN = registers[read_regN]`, combinational.
- Bypass (`BYPASS` set), when `reg_write` is 1 and `write_reg == read_regN`:
  - Each byte with its strobe set takes `write_data`.
  - Each other byte takes the stored value.
  - The zero-register rule overrides bypass.
- `BYPASS` clear: reads return pre-write contents during the write cycle and new contents from the next cycle.
- Simultaneous events:
  - Both ports may read the same address, including while that address is being written; both return identical data.
  - `rst_n` low together with `reg_write` high: the write is discarded.
- Storage has no reset other than the clear sequence; no entry is ever observed non-zero before `ready`.

## Timing
- Read latency: 0 cycles (combinational from address, storage and, with bypass, the write port).
- Write latency: visible on reads from the cycle after the accepting edge, or the same cycle with bypass.
- Clear duration: `ready` rises at the `DEPTH`-th rising edge after the first edge with `rst_n` high. With `DEPTH` = 32, that is 32 edges.
- `ready` changes only on clock edges. It is 0 from reset until clear completes, then stays 1 until the next reset.
- Outputs at reset: `read_data1` = `read_data2` = 0 and `ready` = 0.

## Test plan
- Reset and clear:
  - Hold `rst_n` low 2 cycles, then release.
  - `ready` must rise on exactly the 32nd edge.
  - Reads of every address return 0 before `ready` and after it.
  - `reg_write` asserted during CLEAR has no effect.
- Byte strobes:
  - Write 0xAABBCCDD with strobe 0xF to r5, then 0x11223344 with strobe 0x5 to r5.
  - `read_data1` for r5 must equal 0xAA22CC44.
- Bypass:
  - In the same cycle, write 0xDEADBEEF (strobe 0xF) to r7 with `read_reg1` = `read_reg2` = 7.
  - `BYPASS`=1: both ports show 0xDEADBEEF that cycle.
  - `BYPASS`=0: both ports show the old value that cycle and 0xDEADBEEF next cycle.
- Zero register:
  - Write 0xFFFFFFFF to r0, including in the bypass cycle.
  - `ZERO_REG`=1: r0 reads 0 throughout.
  - `ZERO_REG`=0: r0 reads 0xFFFFFFFF.
- Reset mid-clear:
  - Assert `rst_n` low at clear index 10, release after 1 cycle.
  - `ready` must not rise until 32 further edges.
  - A write of 0x12345678 to r3 attempted before `ready` must not land.
- Parametrisation:
  - Run `DATA_WIDTH`=64, `ADDR_WIDTH`=3.
  - `ready` rises after 8 edges.
  - Full 64-bit write/read of every entry returns the written pattern (0x0123456789ABCDEF xor address).
